// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter that shares one 5:1 single-bit mux among five serial sources.
// A grant is held until the owner drops its request or MAX_HOLD cycles elapse.

module mux5 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       d4,
    input  logic [2:0] sel,
    output logic       y
);
    always_comb begin
        case (sel)
            3'd0:    y = d0;
            3'd1:    y = d1;
            3'd2:    y = d2;
            3'd3:    y = d3;
            3'd4:    y = d4;
            default: y = 1'b0;
        endcase
    end
endmodule

module mux5_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic [4:0] d,
    output logic [4:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       y
);
    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [2:0] last_q;

    logic [2:0] base;
    logic [3:0] sum;
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    logic       owner_req;
    logic       release_now;

    // The current owner becomes lowest priority on release, so search from it.
    assign base        = (state_q == StGrant) ? sel : last_q;
    assign owner_req   = |(req & gnt);
    assign release_now = !owner_req || (cnt_q == 8'(MAX_HOLD - 1));

    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        sum   = 4'd0;
        idx   = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            sum = 4'(base) + 4'(k);
            if (sum >= 4'd5) begin
                sum = sum - 4'd5;
            end
            idx = sum[2:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            gnt     <= 5'd0;
            sel     <= 3'd5;
            busy    <= 1'b0;
            cnt_q   <= 8'd0;
            last_q  <= 3'd4;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q <= StGrant;
                        gnt     <= 5'd1 << win;
                        sel     <= win;
                        busy    <= 1'b1;
                        cnt_q   <= 8'd0;
                    end
                end
                StGrant: begin
                    if (release_now) begin
                        last_q <= sel;
                        cnt_q  <= 8'd0;
                        if (found) begin
                            gnt <= 5'd1 << win;
                            sel <= win;
                        end else begin
                            state_q <= StIdle;
                            gnt     <= 5'd0;
                            sel     <= 3'd5;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt     <= 5'd0;
                    sel     <= 3'd5;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    mux5 u_mux (
        .d0  (d[0]),
        .d1  (d[1]),
        .d2  (d[2]),
        .d3  (d[3]),
        .d4  (d[4]),
        .sel (sel),
        .y   (y)
    );
endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed bench for mux5_rr_arbiter: three instances (MAX_HOLD 8, 4, 1) share
// one stimulus stream; each scenario checks the instance it is about.

module tb_mux5_rr_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] req = 5'd0;
    logic [4:0] d = 5'd0;

    logic [4:0] gnt8, gnt4, gnt1;
    logic [2:0] sel8, sel4, sel1;
    logic       busy8, busy4, busy1;
    logic       y8, y4, y1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux5_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
        .clk(clk), .reset(reset), .req(req), .d(d),
        .gnt(gnt8), .sel(sel8), .busy(busy8), .y(y8)
    );
    mux5_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .reset(reset), .req(req), .d(d),
        .gnt(gnt4), .sel(sel4), .busy(busy4), .y(y4)
    );
    mux5_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .d(d),
        .gnt(gnt1), .sel(sel1), .busy(busy1), .y(y1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // 1: async reset with no clock edge
        #1;
        req   = 5'b11111;
        d     = 5'b11111;
        reset = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt8), 32'h0);
        check("rst_sel", 32'(sel8), 32'd5);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_y", 32'(y8), 32'd0);
        check("rst_sel4", 32'(sel4), 32'd5);
        check("rst_gnt1", 32'(gnt1), 32'h0);
        req = 5'd0;
        d   = 5'd0;
        #1;
        reset = 1'b0;
        tick();

        // 2: single requester on source 2
        req = 5'b00100;
        d   = 5'b00100;
        tick();
        check("single_gnt", 32'(gnt8), 32'h04);
        check("single_sel", 32'(sel8), 32'd2);
        check("single_busy", 32'(busy8), 32'd1);
        check("single_y1", 32'(y8), 32'd1);
        d = 5'b11011;
        #1;
        check("single_y0", 32'(y8), 32'd0);
        tick();
        tick();
        check("single_hold", 32'(gnt8), 32'h04);
        req = 5'd0;
        tick();
        check("single_rel_gnt", 32'(gnt8), 32'h0);
        check("single_rel_sel", 32'(sel8), 32'd5);
        check("single_rel_busy", 32'(busy8), 32'd0);
        check("single_rel_y", 32'(y8), 32'd0);

        // 4: priority after last owner = 1
        pulse_reset();
        req = 5'b00010;
        tick();
        check("prio_own1", 32'(sel8), 32'd1);
        req = 5'd0;
        tick();
        check("prio_idle", 32'(busy8), 32'd0);
        req = 5'b01010;
        tick();
        check("prio_gnt3", 32'(gnt8), 32'h08);
        check("prio_sel3", 32'(sel8), 32'd3);
        tick();
        check("prio_nopreempt", 32'(sel8), 32'd3);
        req = 5'b00010;
        tick();
        check("prio_gnt1", 32'(gnt8), 32'h02);
        check("prio_sel1", 32'(sel8), 32'd1);

        // 5: async reset while source 3 holds the path at cnt=2
        pulse_reset();
        req = 5'b01000;
        tick();
        tick();
        tick();
        check("mid_pre", 32'(sel8), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt8), 32'h0);
        check("mid_rst_sel", 32'(sel8), 32'd5);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        reset = 1'b0;
        tick();
        check("mid_regnt", 32'(gnt8), 32'h08);
        // Fresh count: held through 8 cycles, then re-granted back-to-back.
        for (int i = 0; i < 9; i++) begin
            tick();
            check("mid_hold", 32'(gnt8), 32'h08);
            check("mid_busy", 32'(busy8), 32'd1);
        end

        // 3: full rotation with MAX_HOLD=4
        pulse_reset();
        req = 5'b11111;
        begin
            int owners[6] = '{0, 1, 2, 3, 4, 0};
            for (int j = 0; j < 6; j++) begin
                for (int c = 0; c < 4; c++) begin
                    tick();
                    check("rot_sel", 32'(sel4), 32'(owners[j]));
                    check("rot_gnt", 32'(gnt4), 32'(5'd1 << owners[j]));
                    check("rot_busy", 32'(busy4), 32'd1);
                end
            end
        end

        // 6: MAX_HOLD=1 alternation between sources 0 and 4
        pulse_reset();
        req = 5'b10001;
        d   = 5'b00001;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_sel", 32'(sel1), (i % 2 == 0) ? 32'd0 : 32'd4);
            check("alt_y", 32'(y1), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        req = 5'd0;
        tick();
        check("alt_idle", 32'(busy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
